// File: rtl/multi_filter_corr_engine.sv
// N-filter sliding-window correlator, one serial MAC per filter; out_valid TAPS+1 cycles after the completing sample.
// Result holds until out_ready; in_ready only in FILL. CONV_ROUND_EN selects round-half-up before the shift.
module multi_filter_corr_engine #(
  parameter int N_FILTERS = 2,
  parameter int TAPS      = 16,
  parameter int DATA_W    = 8,
  parameter int STRIDE    = 1,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       load_coef,
  input  logic                       coef_valid,
  input  logic [DATA_W-1:0]          coef_data,
  output logic                       coef_ready,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [N_FILTERS*OUT_W-1:0] out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int ACC_W = 2*DATA_W + $clog2(TAPS);
  localparam int K_W   = $clog2(TAPS);
  localparam int FC_W  = $clog2(TAPS+1);
  localparam int CC_W  = $clog2(N_FILTERS*TAPS);
  localparam int NCOEF = N_FILTERS*TAPS;

`ifdef CONV_ROUND_EN
  localparam int RND_SH = (SHIFT > 0) ? SHIFT-1 : 0;
  localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
`else
  localparam logic [ACC_W:0] RND = '0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_COEF, FILL, COMPUTE, OUTPUT} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] win     [TAPS];
  logic [DATA_W-1:0] coef_sr [NCOEF];
  logic [ACC_W-1:0]  acc     [N_FILTERS];
  logic [CC_W-1:0]   coef_cnt;
  logic [FC_W-1:0]   fill_cnt;
  logic [FC_W-1:0]   fill_need;
  logic [K_W-1:0]    k;
  logic              first_win;
  logic              last_flag;
  logic              coef_fire;
  logic              in_fire;
  logic              fill_met;

  function automatic logic [OUT_W-1:0] scale(input logic [ACC_W-1:0] a);
    logic [ACC_W:0] t;
    t = ({1'b0, a} + RND) >> SHIFT;
    return (|(t >> OUT_W)) ? {OUT_W{1'b1}} : t[OUT_W-1:0];
  endfunction

  assign coef_fire = coef_valid && coef_ready;
  assign in_fire   = in_valid && in_ready;
  assign fill_need = first_win ? FC_W'(TAPS) : FC_W'(STRIDE);
  assign fill_met  = in_fire && (fill_cnt + 1'b1 == fill_need);

  always_comb begin
    state_n    = state;
    coef_ready = (state == LOAD_COEF);
    in_ready   = (state == FILL);
    out_valid  = (state == OUTPUT);
    busy       = (state != IDLE);
    case (state)
      IDLE:      if (start) state_n = load_coef ? LOAD_COEF : FILL;
      LOAD_COEF: if (coef_fire && coef_cnt == CC_W'(NCOEF-1)) state_n = FILL;
      FILL: begin
        if (fill_met)              state_n = COMPUTE;
        else if (in_fire && in_last) state_n = IDLE;  // partial window is dropped
      end
      COMPUTE:   if (k == K_W'(TAPS-1)) state_n = OUTPUT;
      OUTPUT:    if (out_ready) state_n = last_flag ? IDLE : FILL;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    if (state == OUTPUT) begin
      for (int f = 0; f < N_FILTERS; f++) out_data[f*OUT_W +: OUT_W] = scale(acc[f]);
    end
  end

  assign out_last = (state == OUTPUT) && last_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      coef_cnt  <= '0;
      fill_cnt  <= '0;
      k         <= '0;
      first_win <= 1'b0;
      last_flag <= 1'b0;
      for (int i = 0; i < TAPS; i++)      win[i]     <= '0;
      for (int i = 0; i < NCOEF; i++)     coef_sr[i] <= '0;
      for (int f = 0; f < N_FILTERS; f++) acc[f]     <= '0;
    end else begin
      state <= state_n;
      done  <= (state != IDLE) && (state_n == IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            coef_cnt  <= '0;
            fill_cnt  <= '0;
            first_win <= 1'b1;
            last_flag <= 1'b0;
          end
        end
        LOAD_COEF: begin
          // Shift chain: after NCOEF words the first word sits at filter 0 tap 0.
          if (coef_fire) begin
            coef_cnt <= coef_cnt + 1'b1;
            for (int i = 0; i < NCOEF-1; i++) coef_sr[i] <= coef_sr[i+1];
            coef_sr[NCOEF-1] <= coef_data;
          end
        end
        FILL: begin
          if (in_fire) begin
            for (int i = 0; i < TAPS-1; i++) win[i] <= win[i+1];
            win[TAPS-1] <= in_data;
            if (in_last) last_flag <= 1'b1;
            if (fill_met) begin
              fill_cnt  <= '0;
              first_win <= 1'b0;
              k         <= '0;
              for (int f = 0; f < N_FILTERS; f++) acc[f] <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          for (int f = 0; f < N_FILTERS; f++)
            acc[f] <= acc[f] + ACC_W'(win[k]) * ACC_W'(coef_sr[f*TAPS + int'(k)]);
          k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
